// File: rtl/nor3_sweep_checker.sv
// Clocked exhaustive stimulus/response checker for a 3-input NOR under test.
// Walks {a,b,c} through 000..111, samples d once per vector and keeps a fail map.
module nor3_sweep_checker #(
  parameter int HOLD_CYCLES = 10,
  parameter int SETTLE      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       d,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  state_t     state;
  logic [2:0] idx;
  logic [7:0] cnt;

  logic sample_now;
  logic hit;
  logic vec_end;

  // a/b/c mirror idx while driving, so the reference is taken from the applied vector
  assign sample_now = (state == DRIVE) && (cnt == SETTLE_CNT);
  assign hit        = sample_now && (d != ~(a | b | c));
  assign vec_end    = (state == DRIVE) && (cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cnt      <= 8'd0;
      {a, b, c} <= 3'b000;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 4'd0;
      fail_vec <= 8'h00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= DRIVE;
            idx      <= 3'd0;
            cnt      <= 8'd0;
            {a, b, c} <= 3'b000;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 4'd0;
            fail_vec <= 8'h00;
          end
        end
        DRIVE: begin
          cnt <= cnt + 8'd1;
          if (hit) begin
            err_cnt       <= err_cnt + 4'd1;
            fail_vec[idx] <= 1'b1;
          end
          if (vec_end) begin
            if (idx == 3'd7) begin
              // SETTLE may equal HOLD_CYCLES-1, so fold in a same-edge miss
              state     <= DONE;
              {a, b, c} <= 3'b000;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_cnt == 4'd0) && !hit;
            end else begin
              idx       <= idx + 3'd1;
              cnt       <= 8'd0;
              {a, b, c} <= idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor3_sweep_checker.sv
// Scoreboarded random/directed bench for nor3_sweep_checker: a per-run fault table
// decides when the emulated gate lies; the expected result is derived from that table.
module tb_nor3_sweep_checker;
  localparam int H = 10, S = 2, NV = 8, SWEEP = H * NV;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, d;
  logic a, b, c, busy, done, pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_vec;

  nor3_sweep_checker #(.HOLD_CYCLES(H), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d(d),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       pass;
    logic [3:0] err;
    logic [7:0] fv;
    int         done_cyc;
  } exp_t;

  int   total = 0, bad = 0;
  int   active_k = -1;
  bit   wrong [NV][H];
  exp_t sbq[$];
  exp_t last_exp;
  logic done_q = 1'b0;

  // Emulated gate: correct NOR of the vector the bench believes is applied, xor the fault table
  always_comb begin
    d = 1'b0;
    if (active_k >= 0 && cyc >= active_k && cyc - active_k < SWEEP)
      d = (((cyc - active_k) / H) == 0) ^ wrong[(cyc - active_k) / H][(cyc - active_k) % H];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int k);
    exp_t e;
    e.err = 4'd0;
    e.fv  = 8'h00;
    for (int v = 0; v < NV; v++)
      if (wrong[v][S]) begin
        e.fv[v] = 1'b1;
        e.err   = e.err + 4'd1;
      end
    e.pass     = (e.err == 4'd0);
    e.done_cyc = k + SWEEP;
    return e;
  endfunction

  // Result registers for vector v are visible from sweep position v*H+S+1
  function automatic logic [7:0] fv_at(input int m);
    logic [7:0] f;
    f = 8'h00;
    for (int v = 0; v < NV; v++)
      if (wrong[v][S] && (v * H + S + 1 <= m)) f[v] = 1'b1;
    return f;
  endfunction

  function automatic int ones(input logic [7:0] f);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(f[i]);
    return n;
  endfunction

  function automatic int pos();
    return cyc - active_k;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n && active_k >= 0 && pos() >= 0 && pos() < SWEEP) begin
      chk("vector", 32'({a, b, c}), 32'(pos() / H));
      chk("busy_sweep", 32'(busy), 32'd1);
      chk("done_sweep", 32'(done), 32'd0);
      chk("err_running", 32'(err_cnt), 32'(ones(fv_at(pos()))));
      chk("failvec_running", 32'(fail_vec), 32'(fv_at(pos())));
    end
    if (done && !done_q) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)", cyc);
      end else begin
        chk("done_time", 32'(cyc), 32'(sbq[0].done_cyc));
        chk("pass", 32'(pass), 32'(sbq[0].pass));
        chk("err_cnt", 32'(err_cnt), 32'(sbq[0].err));
        chk("fail_vec", 32'(fail_vec), 32'(sbq[0].fv));
        chk("busy_done", 32'(busy), 32'd0);
        chk("abc_done", 32'({a, b, c}), 32'd0);
        void'(sbq.pop_front());
      end
    end
    done_q <= done;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch();
    start    = 1'b1;
    active_k = cyc + 1;
    last_exp = model(cyc + 1);
    sbq.push_back(last_exp);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < SWEEP + 20; i++) begin
      tick();
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done expected done at cyc %0d", last_exp.done_cyc);
      sbq.delete();
    end
    active_k = -1;
    repeat (3) tick();
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_pass", 32'(pass), 32'(last_exp.pass));
    chk("hold_err", 32'(err_cnt), 32'(last_exp.err));
    chk("hold_fv", 32'(fail_vec), 32'(last_exp.fv));
  endtask

  // mode: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 lies before settle, 4 lies at settle of vector 5
  task automatic set_table(input int mode);
    for (int v = 0; v < NV; v++)
      for (int k = 0; k < H; k++)
        case (mode)
          1:       wrong[v][k] = (v == 0);
          2:       wrong[v][k] = (v != 0);
          3:       wrong[v][k] = (k < S);
          4:       wrong[v][k] = (v == 5 && k == S);
          default: wrong[v][k] = 1'b0;
        endcase
  endtask

  task automatic idle_chk(input string name);
    chk(name, 32'({a, b, c, busy, done}), 32'd0);
  endtask

  initial begin
    set_table(0);
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) begin
      tick();
      chk("reset_outs", 32'({a, b, c, busy, done, pass, err_cnt, fail_vec}), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (5) tick();
    idle_chk("idle_after_reset");

    set_table(0); launch(); wait_done();
    set_table(1); launch(); wait_done();
    set_table(2); launch(); wait_done();
    set_table(3); launch(); wait_done();
    set_table(4); launch(); wait_done();

    // start during vector 4 must be ignored
    set_table(0); launch();
    repeat (4 * H + 2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();

    // restart straight from DONE after a failing run
    set_table(2); launch(); wait_done();
    set_table(0); launch(); wait_done();

    // reset in the middle of vector 3
    set_table(2); launch();
    repeat (3 * H + 4) tick();
    rst_n = 1'b0;
    tick();
    chk("midreset_abc", 32'({a, b, c}), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_err", 32'(err_cnt), 32'd0);
    sbq.delete();
    active_k = -1;
    rst_n = 1'b1;
    repeat (3) tick();
    idle_chk("idle_after_midreset");
    set_table(0); launch(); wait_done();

    repeat (8) begin
      for (int v = 0; v < NV; v++)
        for (int k = 0; k < H; k++)
          wrong[v][k] = ($urandom_range(0, 2) == 0);
      launch();
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
